// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller.
//   REG_IDX_W      : width of an architectural register index (5 -> r0..r31)
//   hazState_t     : FSM state encoding (RUN=0, DIVWAIT=1)
//   loadUseHazard  : detects a load in EX whose destination feeds the
//                    instruction currently in ID
// ---------------------------------------------------------------------------
package hazard_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic {
        RUN     = 1'b0,
        DIVWAIT = 1'b1
    } hazState_t;

    // r0 is hard-wired to zero, so a load targeting it never creates a
    // real dependency.
    function automatic logic loadUseHazard(
        input logic                 memRead,
        input logic [REG_IDX_W-1:0] exRt,
        input logic [REG_IDX_W-1:0] idRs,
        input logic [REG_IDX_W-1:0] idRt
    );
        return memRead && (exRt != '0) && ((exRt == idRs) || (exRt == idRt));
    endfunction

endpackage

// File: rtl/hazard_div_timer.sv
// ---------------------------------------------------------------------------
// hazard_div_timer
// Down-counter that times how long a multi-cycle divide holds the EX stage.
// Only built when HAZARD_DIV_EN is defined.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears the count)
//   load       : load loadValue into the counter this edge
//   loadValue  : cycles remaining after the divide's first EX cycle, minus one
//   enable     : count down (held while the controller is waiting)
//   done       : counter is zero
// ---------------------------------------------------------------------------
`ifdef HAZARD_DIV_EN
module hazard_div_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] loadValue,
    input  logic             enable,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Five-stage pipeline hazard unit: load-use stalls, taken-branch flushes and
// (optionally) multi-cycle divide stalls. Control outputs are combinational
// from the current state and inputs; state and the stall counter are
// registered.
//
// Optional feature macro: HAZARD_DIV_EN
//   defined   -> DIVWAIT state and divide timer present, IDEXdivStart honoured
//   undefined -> RUN-only controller, IDEXdivStart ignored
//
// Parameters:
//   DIV_LATENCY : total EX occupancy of a divide in cycles (2..63)
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   IDEXmemRead, IDEXregisterRt      : load in EX and its destination
//   IFIDregisterRs, IFIDregisterRt   : sources of the instruction in ID
//   branchTaken                      : branch/jump in EX resolved taken
//   IDEXdivStart                     : divide entering EX this cycle
//   pcWrite, IFIDwrite, IDEXwrite    : pipeline register load enables
//   IFIDflush, IDEXflush, EXMEMflush : bubble insertion on the next edge
//   pcSrcBranch                      : PC takes the branch target
//   stallCycles                      : saturating count of pcWrite=0 cycles
// ---------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DIV_LATENCY = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 IDEXmemRead,
    input  logic [REG_IDX_W-1:0] IDEXregisterRt,
    input  logic [REG_IDX_W-1:0] IFIDregisterRs,
    input  logic [REG_IDX_W-1:0] IFIDregisterRt,
    input  logic                 branchTaken,
    input  logic                 IDEXdivStart,
    output logic                 pcWrite,
    output logic                 IFIDwrite,
    output logic                 IDEXwrite,
    output logic                 IFIDflush,
    output logic                 IDEXflush,
    output logic                 EXMEMflush,
    output logic                 pcSrcBranch,
    output logic [31:0]          stallCycles
);

    // The first EX cycle of a divide happens in RUN, and the counter==0
    // cycle is the last DIVWAIT cycle, hence the -2.
    localparam logic [5:0] DIV_LOAD = 6'(DIV_LATENCY - 2);

    logic        loadUse;
    logic [31:0] stallCnt;

    assign loadUse = loadUseHazard(IDEXmemRead, IDEXregisterRt,
                                   IFIDregisterRs, IFIDregisterRt);

`ifdef HAZARD_DIV_EN
    hazState_t state;
    hazState_t stateNext;
    logic      divLoad;
    logic      divDone;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    hazard_div_timer #(
        .CNT_W (6)
    ) uDivTimer (
        .clk       (clk),
        .rst       (rst),
        .load      (divLoad),
        .loadValue (DIV_LOAD),
        .enable    (state == DIVWAIT),
        .done      (divDone)
    );
`else
    // Divide support compiled out: these inputs/constants are intentionally
    // left without a consumer.
    logic unusedCfg;
    assign unusedCfg = ^{IDEXdivStart, DIV_LOAD};
`endif

    always_comb begin
        pcWrite     = 1'b1;
        IFIDwrite   = 1'b1;
        IDEXwrite   = 1'b1;
        IFIDflush   = 1'b0;
        IDEXflush   = 1'b0;
        EXMEMflush  = 1'b0;
        pcSrcBranch = 1'b0;
`ifdef HAZARD_DIV_EN
        stateNext   = state;
        divLoad     = 1'b0;
`endif

        if (rst) begin
            // Freeze fetch and keep every pipeline register empty.
            pcWrite    = 1'b0;
            IFIDwrite  = 1'b0;
            IDEXwrite  = 1'b0;
            IFIDflush  = 1'b1;
            IDEXflush  = 1'b1;
            EXMEMflush = 1'b1;
`ifdef HAZARD_DIV_EN
            stateNext  = RUN;
        end else if (state == DIVWAIT) begin
            // Hold the divide in EX and keep bubbles flowing into MEM until
            // the last cycle, when the result is released.
            pcWrite    = 1'b0;
            IFIDwrite  = 1'b0;
            IDEXwrite  = 1'b0;
            EXMEMflush = !divDone;
            if (divDone) begin
                stateNext = RUN;
            end
`endif
        end else if (branchTaken) begin
            // Redirect fetch and squash the two wrong-path instructions.
            pcSrcBranch = 1'b1;
            IFIDflush   = 1'b1;
            IDEXflush   = 1'b1;
`ifdef HAZARD_DIV_EN
        end else if (IDEXdivStart) begin
            stateNext = DIVWAIT;
            divLoad   = 1'b1;
`endif
        end else if (loadUse) begin
            // Hold PC and IF/ID one cycle, send a bubble into EX.
            pcWrite   = 1'b0;
            IFIDwrite = 1'b0;
            IDEXflush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt <= '0;
        end else if (!pcWrite && (stallCnt != 32'hFFFF_FFFF)) begin
            stallCnt <= stallCnt + 32'd1;
        end
    end

    assign stallCycles = stallCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    // ctl = {pcWrite, IFIDwrite, IDEXwrite, IFIDflush, IDEXflush, EXMEMflush, pcSrcBranch}
    localparam logic [6:0] DEF  = 7'b111_000_0;
    localparam logic [6:0] RSTV = 7'b000_111_0;
    localparam logic [6:0] LU   = 7'b001_010_0;
    localparam logic [6:0] BR   = 7'b111_110_1;
    localparam logic [6:0] DIVW = 7'b000_001_0;
    localparam logic [6:0] DIVL = 7'b000_000_0;

    logic        clk = 1'b0;
    logic        rst;
    logic        IDEXmemRead;
    logic [4:0]  IDEXregisterRt;
    logic [4:0]  IFIDregisterRs;
    logic [4:0]  IFIDregisterRt;
    logic        branchTaken;
    logic        IDEXdivStart;
    logic        pcWrite, IFIDwrite, IDEXwrite;
    logic        IFIDflush, IDEXflush, EXMEMflush, pcSrcBranch;
    logic [31:0] stallCycles;
    logic [6:0]  ctl;

    int checks = 0;
    int passes = 0;
    logic [31:0] expStall = 32'd0;

    assign ctl = {pcWrite, IFIDwrite, IDEXwrite, IFIDflush, IDEXflush, EXMEMflush, pcSrcBranch};

    always #5 clk = ~clk;

    hazard_ctrl #(.DIV_LATENCY(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .IDEXmemRead    (IDEXmemRead),
        .IDEXregisterRt (IDEXregisterRt),
        .IFIDregisterRs (IFIDregisterRs),
        .IFIDregisterRt (IFIDregisterRt),
        .branchTaken    (branchTaken),
        .IDEXdivStart   (IDEXdivStart),
        .pcWrite        (pcWrite),
        .IFIDwrite      (IFIDwrite),
        .IDEXwrite      (IDEXwrite),
        .IFIDflush      (IFIDflush),
        .IDEXflush      (IDEXflush),
        .EXMEMflush     (EXMEMflush),
        .pcSrcBranch    (pcSrcBranch),
        .stallCycles    (stallCycles)
    );

    // Inputs change 1ns after a rising edge; outputs are sampled on the
    // falling edge that follows.
    task automatic drive(input logic mr, input logic [4:0] exRt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic br, input logic ds);
        IDEXmemRead    = mr;
        IDEXregisterRt = exRt;
        IFIDregisterRs = rs;
        IFIDregisterRt = rt;
        branchTaken    = br;
        IDEXdivStart   = ds;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        @(negedge clk);
        checks++; if (ctl !== RSTV) $display("FAIL reset_ctl got %b want %b", ctl, RSTV); else passes++;
        checks++; if (stallCycles !== 32'd0) $display("FAIL reset_stall got %0d want 0", stallCycles); else passes++;
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ctl !== DEF) $display("FAIL first_run_ctl got %b want %b", ctl, DEF); else passes++;
        checks++; if (stallCycles !== 32'd0) $display("FAIL first_run_stall got %0d want 0", stallCycles); else passes++;
        expStall = 32'd0;
    endtask

    task automatic test_load_use();
        // load r8, consumer reads r8 as Rt
        nextCycle();
        drive(1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (ctl !== LU) $display("FAIL lu_rt_ctl got %b want %b", ctl, LU); else passes++;
        nextCycle();
        expStall = expStall + 1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (ctl !== DEF) $display("FAIL lu_after_ctl got %b want %b", ctl, DEF); else passes++;
        checks++; if (stallCycles !== 32'd1) $display("FAIL lu_rt_stall got %0d want 1", stallCycles); else passes++;
        // match on Rs
        nextCycle();
        drive(1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (ctl !== LU) $display("FAIL lu_rs_ctl got %b want %b", ctl, LU); else passes++;
        nextCycle();
        expStall = expStall + 1;
        // no register match
        drive(1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (ctl !== DEF) $display("FAIL lu_nomatch_ctl got %b want %b", ctl, DEF); else passes++;
        checks++; if (stallCycles !== 32'd2) $display("FAIL lu_rs_stall got %0d want 2", stallCycles); else passes++;
        nextCycle();
        // match but not a load
        drive(1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (ctl !== DEF) $display("FAIL lu_notload_ctl got %b want %b", ctl, DEF); else passes++;
    endtask

    task automatic test_r0();
        nextCycle();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (ctl !== DEF) $display("FAIL r0_ctl got %b want %b", ctl, DEF); else passes++;
        nextCycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (stallCycles !== expStall) $display("FAIL r0_stall got %0d want %0d", stallCycles, expStall); else passes++;
    endtask

    task automatic test_branch();
        nextCycle();
        drive(1'b1, 5'd4, 5'd4, 5'd1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (ctl !== BR) $display("FAIL branch_ctl got %b want %b", ctl, BR); else passes++;
        nextCycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (stallCycles !== expStall) $display("FAIL branch_stall got %0d want %0d", stallCycles, expStall); else passes++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            drive(1'b1, 5'd12, 5'd12, 5'd2, 1'b0, 1'b0);
            @(negedge clk);
            checks++; if (ctl !== LU) $display("FAIL b2b_ctl%0d got %b want %b", i, ctl, LU); else passes++;
            expStall = expStall + 1;
        end
        nextCycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (stallCycles !== expStall) $display("FAIL b2b_stall got %0d want %0d", stallCycles, expStall); else passes++;
    endtask

`ifdef HAZARD_DIV_EN
    task automatic test_div();
        nextCycle();
        drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (ctl !== DEF) $display("FAIL div_start_ctl got %b want %b", ctl, DEF); else passes++;
        // first wait cycle: branch and load-use must be ignored
        nextCycle();
        drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (ctl !== DIVW) $display("FAIL div_w1_ctl got %b want %b", ctl, DIVW); else passes++;
        nextCycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (ctl !== DIVW) $display("FAIL div_w2_ctl got %b want %b", ctl, DIVW); else passes++;
        nextCycle();
        @(negedge clk);
        checks++; if (ctl !== DIVL) $display("FAIL div_last_ctl got %b want %b", ctl, DIVL); else passes++;
        nextCycle();
        expStall = expStall + 3;
        @(negedge clk);
        checks++; if (ctl !== DEF) $display("FAIL div_done_ctl got %b want %b", ctl, DEF); else passes++;
        checks++; if (stallCycles !== expStall) $display("FAIL div_stall got %0d want %0d", stallCycles, expStall); else passes++;
    endtask

    task automatic test_rst_in_div();
        nextCycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        nextCycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (ctl !== DIVW) $display("FAIL rdiv_w1_ctl got %b want %b", ctl, DIVW); else passes++;
        nextCycle();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ctl !== RSTV) $display("FAIL rdiv_rst_ctl got %b want %b", ctl, RSTV); else passes++;
        nextCycle();
        rst = 1'b0;
        expStall = 32'd0;
        @(negedge clk);
        checks++; if (ctl !== DEF) $display("FAIL rdiv_run_ctl got %b want %b", ctl, DEF); else passes++;
        checks++; if (stallCycles !== 32'd0) $display("FAIL rdiv_stall got %0d want 0", stallCycles); else passes++;
    endtask
`else
    task automatic test_div_ignored();
        nextCycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (ctl !== DEF) $display("FAIL divign_ctl got %b want %b", ctl, DEF); else passes++;
        nextCycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (ctl !== DEF) $display("FAIL divign_next_ctl got %b want %b", ctl, DEF); else passes++;
        checks++; if (stallCycles !== expStall) $display("FAIL divign_stall got %0d want %0d", stallCycles, expStall); else passes++;
    endtask
`endif

    task automatic test_saturation();
        nextCycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        force dut.stallCnt = 32'hFFFF_FFFE;
        #1;
        release dut.stallCnt;
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            drive(1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0);
            @(negedge clk);
            checks++; if (ctl !== LU) $display("FAIL sat_ctl%0d got %b want %b", i, ctl, LU); else passes++;
            nextCycle();
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
            @(negedge clk);
            checks++; if (stallCycles !== 32'hFFFF_FFFF) $display("FAIL sat_stall%0d got %h want ffffffff", i, stallCycles); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_r0();
        test_branch();
        test_back_to_back();
`ifdef HAZARD_DIV_EN
        test_div();
        test_rst_in_div();
`else
        test_div_ignored();
`endif
        test_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter DIV_LATENCY, default 32, total EX-stage occupancy in cycles of a divide; legal range 2..63.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 IDEXmemRead  input  1  instruction in EX is a load.
REQ-005 IDEXregisterRt  input  5  load destination register in EX.
REQ-006 IFIDregisterRs, IFIDregisterRt  input  5 each  source registers of instruction in ID.
REQ-007 branchTaken  input  1  branch/jump in EX resolved taken this cycle.
REQ-008 IDEXdivStart  input  1  divide entering EX this cycle (used only with HAZARD_DIV_EN).
REQ-009 pcWrite  output  1  PC update enable.
REQ-010 IFIDwrite  output  1  IF/ID register load enable.
REQ-011 IDEXwrite  output  1  ID/EX register load enable.
REQ-012 IFIDflush, IDEXflush, EXMEMflush  output  1 each  insert bubble into the named register on next edge.
REQ-013 pcSrcBranch  output  1  PC selects branch target.
REQ-014 stallCycles  output  32  count of cycles with pcWrite=0 since reset.

Function
REQ-015 FSM states: RUN, DIVWAIT; outputs are Mealy (combinational from state and inputs), state/counters registered.
REQ-016 Default in RUN: pcWrite=1, IFIDwrite=1, IDEXwrite=1, all flushes 0, pcSrcBranch=0.
REQ-017 Load-use hazard = IDEXmemRead && IDEXregisterRt!=0 && (IDEXregisterRt==IFIDregisterRs || IDEXregisterRt==IFIDregisterRt).
REQ-018 Load-use in RUN: same cycle pcWrite=0, IFIDwrite=0, IDEXflush=1; exactly one stall cycle per load, no extra state.
REQ-019 branchTaken in RUN: same cycle pcSrcBranch=1, pcWrite=1, IFIDflush=1, IDEXflush=1; two-instruction penalty.
REQ-020 Priority in RUN: branchTaken > divide > load-use; load-use suppressed when branchTaken=1.
REQ-021 IDEXdivStart in RUN with branchTaken=0: enter DIVWAIT, load counter with DIV_LATENCY-2.
REQ-022 DIVWAIT: pcWrite=0, IFIDwrite=0, IDEXwrite=0, EXMEMflush=1; counter decrements per cycle; at counter==0 return to RUN with EXMEMflush=0 that cycle, so divide occupies EX exactly DIV_LATENCY cycles.
REQ-023 DIVWAIT ignores branchTaken, IDEXdivStart and load-use inputs.
REQ-024 stallCycles increments on every non-reset cycle with pcWrite=0; saturates at 32'hFFFFFFFF, no wrap.

Reset
REQ-025 While rst=1: pcWrite=0, IFIDwrite=0, IDEXwrite=0, IFIDflush=1, IDEXflush=1, EXMEMflush=1, pcSrcBranch=0; stallCycles not incremented.
REQ-026 On edge with rst=1: state=RUN, div counter=0, stallCycles=0; rst mid-DIVWAIT aborts the wait.
REQ-027 First cycle after rst deasserts behaves as RUN.

Configuration
REQ-028 Macro HAZARD_DIV_EN: defined -> DIVWAIT, div counter and REQ-021..023 present; undefined -> IDEXdivStart ignored, FSM has only RUN, no counter logic.

Structure
REQ-029 Shared package holds FSM state encoding (RUN=1'b0, DIVWAIT=1'b1) and register-index width constant (5).
REQ-030 Single module; optional sub-module hazard_div_timer (counter + done flag) under HAZARD_DIV_EN.

Verification
REQ-031 Load r8 in EX, IFIDregisterRt=8 -> one cycle pcWrite=0, IFIDwrite=0, IDEXflush=1; stallCycles=1.
REQ-032 Load to r0, IFIDregisterRs=0 -> no stall, all defaults.
REQ-033 branchTaken=1 with simultaneous load-use match -> pcSrcBranch=1, IFIDflush=1, IDEXflush=1, pcWrite=1, no stall.
REQ-034 HAZARD_DIV_EN, DIV_LATENCY=4, IDEXdivStart pulse -> pcWrite=0 for exactly 3 cycles, then RUN; stallCycles=3.
REQ-035 rst asserted 2nd cycle of DIVWAIT -> reset outputs per REQ-025, then RUN, stallCycles=0.
REQ-036 stallCycles forced near 32'hFFFFFFFE, three load-use stalls -> holds 32'hFFFFFFFF.
